// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game datapath: shell FSM states,
// fixed-point format, screen limits and direction encodings.
package tank_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCOORD_W = 11;
    localparam int unsigned FRAC_W   = 4;
    localparam int unsigned YFP_W    = SCOORD_W + FRAC_W;

    localparam int unsigned X_MAX = 639;
    localparam int unsigned Y_MAX = 479;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } shell_state_t;

    // Shell kinematic state: integer x, 11.4 fixed-point y, vertical speed in 1/16 px/frame
    typedef struct packed {
        logic signed [SCOORD_W-1:0] x;
        logic signed [YFP_W-1:0]    y_fp;
        logic signed [SCOORD_W-1:0] vy;
    } shell_kin_t;

    // Clamp a signed screen coordinate to the visible, unsigned range
    function automatic logic [COORD_W-1:0] sat_coord(input logic signed [SCOORD_W-1:0] v);
        return v[SCOORD_W-1] ? '0 : v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/shell_hit_detect.sv
// Combinational box-overlap test of a point against a square target:
// |x - tx| <= ts and |y - ty| <= ts, all operands signed 11-bit.
module shell_hit_detect
    import tank_pkg::*;
(
    input  logic signed [SCOORD_W-1:0] i_x,
    input  logic signed [SCOORD_W-1:0] i_y,
    input  logic signed [SCOORD_W-1:0] i_tx,
    input  logic signed [SCOORD_W-1:0] i_ty,
    input  logic signed [SCOORD_W-1:0] i_ts,
    output logic                       o_overlap_c
);

    localparam int unsigned DW = SCOORD_W + 1;

    logic signed [DW-1:0] w_dx;
    logic signed [DW-1:0] w_dy;
    logic signed [DW-1:0] w_adx;
    logic signed [DW-1:0] w_ady;
    logic signed [DW-1:0] w_s;

    // One extra bit keeps the difference of two 11-bit values from wrapping
    assign w_dx  = {i_x[SCOORD_W-1], i_x} - {i_tx[SCOORD_W-1], i_tx};
    assign w_dy  = {i_y[SCOORD_W-1], i_y} - {i_ty[SCOORD_W-1], i_ty};
    assign w_adx = w_dx[DW-1] ? -w_dx : w_dx;
    assign w_ady = w_dy[DW-1] ? -w_dy : w_dy;
    assign w_s   = {i_ts[SCOORD_W-1], i_ts};

    assign o_overlap_c = !w_s[DW-1] && (w_adx <= w_s) && (w_ady <= w_s);

endmodule

// File: rtl/shell_ballistics.sv
// Single-shell projectile stage: launches on a rising edge of shoot, integrates
// a gravity trajectory once per frame and reports one-frame hit/miss pulses.
module shell_ballistics #(
    parameter int unsigned VX         = 2,
    parameter int unsigned VY_BASE    = 64,
    parameter int unsigned GRAV       = 2,
    parameter int unsigned LAUNCH_DY  = 6,
    parameter int unsigned Y_MAX      = tank_pkg::Y_MAX,
    parameter int unsigned X_MAX      = tank_pkg::X_MAX,
    parameter int unsigned FLIGHT_MAX = 511
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       shoot,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] Direction,
    input  logic [9:0] y_component,
    input  logic [9:0] enemyX,
    input  logic [9:0] enemyY,
    input  logic [9:0] enemyS,
    output logic [9:0] ShellX,
    output logic [9:0] ShellY,
    output logic       shell_active,
    output logic       hit,
    output logic       miss
);
    import tank_pkg::COORD_W;
    import tank_pkg::SCOORD_W;
    import tank_pkg::FRAC_W;
    import tank_pkg::YFP_W;
    import tank_pkg::DIR_LEFT;
    import tank_pkg::shell_state_t;
    import tank_pkg::IDLE;
    import tank_pkg::FLIGHT;
    import tank_pkg::DONE;
    import tank_pkg::shell_kin_t;
    import tank_pkg::sat_coord;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned VY_CLAMP = 255;

    logic             r_shoot_q;
    shell_state_t     r_state;
    shell_kin_t       r_kin;
    logic             r_dir_left;
    logic [CNT_W-1:0] r_cnt;

    logic                       w_fire;
    logic signed [SCOORD_W-1:0] w_vy_sum;
    logic signed [SCOORD_W-1:0] w_vy_launch;
    logic [COORD_W-1:0]         w_y_launch;
    shell_kin_t                 w_kin_launch;
    shell_kin_t                 w_kin_next;
    logic signed [SCOORD_W-1:0] w_ny;
    logic                       w_overlap;
    logic                       w_out;
    logic                       w_timeout;

    assign w_fire = shoot & ~r_shoot_q;

    // Launch state: vertical speed clamped to [0, VY_CLAMP], launch point floored at row 0
    always_comb begin
        w_vy_sum = SCOORD_W'(VY_BASE) + {y_component[COORD_W-1], y_component};
        if (w_vy_sum[SCOORD_W-1]) begin
            w_vy_launch = '0;
        end else if (w_vy_sum > SCOORD_W'(VY_CLAMP)) begin
            w_vy_launch = SCOORD_W'(VY_CLAMP);
        end else begin
            w_vy_launch = w_vy_sum;
        end

        w_y_launch = (TankY < COORD_W'(LAUNCH_DY)) ? '0 : TankY - COORD_W'(LAUNCH_DY);

        w_kin_launch.x    = {1'b0, TankX};
        w_kin_launch.y_fp = {1'b0, w_y_launch, {FRAC_W{1'b0}}};
        w_kin_launch.vy   = w_vy_launch;
    end

    // Candidate next-frame state; y decreases while vy is positive (upward)
    always_comb begin
        w_kin_next.x    = r_dir_left ? r_kin.x - SCOORD_W'(VX) : r_kin.x + SCOORD_W'(VX);
        w_kin_next.y_fp = r_kin.y_fp - {{(YFP_W - SCOORD_W){r_kin.vy[SCOORD_W-1]}}, r_kin.vy};
        w_kin_next.vy   = r_kin.vy - SCOORD_W'(GRAV);
        w_ny            = w_kin_next.y_fp[YFP_W-1:FRAC_W];
    end

    // Negative y (above the screen top) is deliberately not an out-of-bounds condition
    assign w_out = w_kin_next.x[SCOORD_W-1]
                || (w_kin_next.x[COORD_W-1:0] > COORD_W'(X_MAX))
                || (!w_ny[SCOORD_W-1] && (w_ny[COORD_W-1:0] >= COORD_W'(Y_MAX)));

    assign w_timeout = (r_cnt >= CNT_W'(FLIGHT_MAX));

    shell_hit_detect u_hit_detect (
        .i_x         (w_kin_next.x),
        .i_y         (w_ny),
        .i_tx        ({1'b0, enemyX}),
        .i_ty        ({1'b0, enemyY}),
        .i_ts        ({1'b0, enemyS}),
        .o_overlap_c (w_overlap)
    );

    // Flight FSM; hit has priority over miss, and a miss leaves the last drawn position
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_shoot_q    <= 1'b0;
            r_kin        <= '0;
            r_dir_left   <= 1'b0;
            r_cnt        <= '0;
            ShellX       <= '0;
            ShellY       <= '0;
            shell_active <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
        end else begin
            r_shoot_q <= shoot;
            hit       <= 1'b0;
            miss      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_kin        <= w_kin_launch;
                        r_dir_left   <= (Direction == DIR_LEFT);
                        r_cnt        <= '0;
                        ShellX       <= TankX;
                        ShellY       <= w_y_launch;
                        shell_active <= 1'b1;
                        r_state      <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (w_overlap) begin
                        hit     <= 1'b1;
                        ShellX  <= sat_coord(w_kin_next.x);
                        ShellY  <= sat_coord(w_ny);
                        r_state <= DONE;
                    end else if (w_out || w_timeout) begin
                        miss    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_kin  <= w_kin_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        ShellX <= sat_coord(w_kin_next.x);
                        ShellY <= sat_coord(w_ny);
                    end
                end
                DONE: begin
                    shell_active <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shell_ballistics.sv
// Scoreboard bench for shell_ballistics: directed launches push hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_shell_ballistics;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       shoot;
    logic [9:0] TankX, TankY, y_component, enemyX, enemyY, enemyS;
    logic [1:0] Direction;
    logic [9:0] ShellX, ShellY;
    logic       shell_active, hit, miss;

    shell_ballistics dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .shoot        (shoot),
        .TankX        (TankX),
        .TankY        (TankY),
        .Direction    (Direction),
        .y_component  (y_component),
        .enemyX       (enemyX),
        .enemyY       (enemyY),
        .enemyS       (enemyS),
        .ShellX       (ShellX),
        .ShellY       (ShellY),
        .shell_active (shell_active),
        .hit          (hit),
        .miss         (miss)
    );

    always #5 frame_clk = ~frame_clk;

    int cyc = 0;
    always @(posedge frame_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic       act;
        logic       h;
        logic       m;
        logic       chk_pos;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: service every expectation due at or before the current cycle
    always @(negedge frame_clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (mon_e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: expectation for cycle %0d not serviced (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (shell_active !== mon_e.act || hit !== mon_e.h || miss !== mon_e.m ||
                         (mon_e.chk_pos && (ShellX !== mon_e.x || ShellY !== mon_e.y))) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got act=%b hit=%b miss=%b X=%0d Y=%0d, expected act=%b hit=%b miss=%b X=%0d Y=%0d%s",
                         mon_e.name, cyc, shell_active, hit, miss, ShellX, ShellY,
                         mon_e.act, mon_e.h, mon_e.m, mon_e.x, mon_e.y, mon_e.chk_pos ? "" : " (pos unchecked)");
            end
        end
    end

    task automatic expect_at(input int c, input string nm, input logic a, input logic h,
                             input logic m, input logic cp, input int x, input int y);
        exp_t e;
        e.cyc = c; e.name = nm; e.act = a; e.h = h; e.m = m; e.chk_pos = cp;
        e.x = 10'(x); e.y = 10'(y);
        sb_q.push_back(e);
    endtask

    // Advance to 1 ns after the posedge that makes cyc == n
    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    // Frame k of this launch is visible at cycle f0 + k
    task automatic launch(input int tx, input int ty, input int d, input int yc,
                          input int ex, input int ey, input int es, output int f0);
        TankX = 10'(tx); TankY = 10'(ty); Direction = 2'(d); y_component = 10'(yc);
        enemyX = 10'(ex); enemyY = 10'(ey); enemyS = 10'(es);
        shoot = 1'b1;
        f0 = cyc + 1;
    endtask

    initial begin
        int f;
        int p;
        Reset = 1'b1; shoot = 1'b0;
        TankX = '0; TankY = '0; Direction = '0; y_component = '0;
        enemyX = '0; enemyY = '0; enemyS = '0;

        goto_cyc(3);
        Reset = 1'b0;
        expect_at(cyc, "reset_state", 0, 0, 0, 1, 0, 0);
        goto_cyc(cyc + 2);

        // Launch below row 6 with clamped-high vy: flies above screen top, then reset mid-flight
        launch(100, 3, 1, 300, 600, 400, 2, f);
        expect_at(f + 0, "top_f0", 1, 0, 0, 1, 100, 0);
        expect_at(f + 1, "top_f1_neg_y", 1, 0, 0, 1, 102, 0);
        expect_at(f + 2, "top_f2_neg_y", 1, 0, 0, 1, 104, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 4); Reset = 1'b1; p = cyc;
        expect_at(p + 1, "reset_midflight", 0, 0, 0, 1, 0, 0);
        goto_cyc(p + 2); Reset = 1'b0;
        expect_at(p + 3, "reset_after", 0, 0, 0, 1, 0, 0);
        goto_cyc(p + 5);

        // Ascent, apex and ground miss
        launch(50, 200, 1, 0, 600, 50, 2, f);
        expect_at(f + 0,   "asc_f0",    1, 0, 0, 1, 50, 194);
        expect_at(f + 1,   "asc_f1",    1, 0, 0, 1, 52, 190);
        expect_at(f + 2,   "asc_f2",    1, 0, 0, 1, 54, 186);
        expect_at(f + 32,  "asc_apex",  1, 0, 0, 1, 114, 128);
        expect_at(f + 107, "asc_f107",  1, 0, 0, 1, 264, 474);
        expect_at(f + 108, "asc_ground",1, 0, 1, 1, 264, 474);
        expect_at(f + 109, "asc_idle",  0, 0, 0, 0, 0, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 111);

        // Hit on target (60,175) half-size 1
        launch(50, 200, 1, 0, 60, 175, 1, f);
        expect_at(f + 4, "hit_f4_near", 1, 0, 0, 1, 58, 178);
        expect_at(f + 5, "hit_pulse",   1, 1, 0, 1, 60, 175);
        expect_at(f + 6, "hit_done",    0, 0, 0, 0, 0, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 8);

        // Left screen edge miss holds last position
        launch(3, 200, 0, 0, 600, 50, 2, f);
        expect_at(f + 0, "edge_f0",   1, 0, 0, 1, 3, 194);
        expect_at(f + 1, "edge_f1",   1, 0, 0, 1, 1, 190);
        expect_at(f + 2, "edge_miss", 1, 0, 1, 1, 1, 190);
        expect_at(f + 3, "edge_done", 0, 0, 0, 0, 0, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 5);

        // Re-fire during flight is ignored
        launch(50, 200, 1, 0, 600, 50, 2, f);
        expect_at(f + 4,   "refire_f4",   1, 0, 0, 1, 58, 178);
        expect_at(f + 5,   "refire_f5",   1, 0, 0, 1, 60, 175);
        expect_at(f + 108, "refire_miss", 1, 0, 1, 1, 264, 474);
        expect_at(f + 109, "refire_idle", 0, 0, 0, 0, 0, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 3); shoot = 1'b1;
        goto_cyc(f + 6); shoot = 1'b0;
        goto_cyc(f + 111);

        // Aim clamp to vy=0, Direction=2 treated as right, pure descent to the ground
        launch(50, 200, 2, 960, 600, 50, 2, f);
        expect_at(f + 0,  "clamp_f0",   1, 0, 0, 1, 50, 194);
        expect_at(f + 1,  "clamp_f1",   1, 0, 0, 1, 52, 194);
        expect_at(f + 68, "clamp_f68",  1, 0, 0, 1, 186, 478);
        expect_at(f + 69, "clamp_miss", 1, 0, 1, 1, 186, 478);
        expect_at(f + 70, "clamp_idle", 0, 0, 0, 0, 0, 0);
        goto_cyc(f + 1); shoot = 1'b0;
        goto_cyc(f + 72);

        goto_cyc(cyc + 3);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
